sq_loop_ctrl: RTL and testbench
===============================

Name: sq_loop_ctrl

Overview:
Sequencer for the iterated modular-squaring loop (VDF evaluation). Accepts an initial value and an iteration count T. Drives the squarer operands from a held state register, waits the fixed squarer-plus-reduction latency, and captures the reduced feedback value. After T iterations it presents the final value on a valid/ready result port. Sits between host/load logic and the squarer → reduction datapath; it owns loop state only, no arithmetic.

Parameters:
NUM_ELEMENTS, 33, number of redundant-form limbs in the operand
BIT_LEN, 17, width of each limb (WORD_LEN + 1 redundant bit)
ITER_W, 64, width of the iteration count and counters
LOOP_LATENCY, 4, cycles from operand issue to valid reduced feedback; legal range ≥1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
start_valid  in  1  load request
start_ready  out  1  high only in IDLE with abort low
start_iters  in  ITER_W  iteration count T
start_value  in  BIT_LEN x NUM_ELEMENTS  initial value
abort  in  1  synchronous cancel
sq_in  out  BIT_LEN x NUM_ELEMENTS  squarer A and B operand; always equals cur_value register
sq_issue  out  1  one-cycle pulse: sq_in is a new operand this cycle
fb_value  in  BIT_LEN x NUM_ELEMENTS  reduced square returned by the datapath
result_valid  out  1  final value available
result_ready  in  1  consumer accepts result
result_value  out  BIT_LEN x NUM_ELEMENTS  final value (= cur_value)
busy  out  1  state != IDLE
iter_done  out  ITER_W  iterations completed in the current run
perf_cycles  out  ITER_W  loop cycle count (optional feature)

Behaviour:
- Reset (rst_n low, async): state=IDLE; cur_value, iter_rem, iter_done, lat_cnt, perf_cycles = 0; sq_issue=0; result_valid=0; busy=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: start_ready=1. On start_valid&&start_ready: cur_value<=start_value, iter_rem<=start_iters, iter_done<=0. Next state is DONE if start_iters==0, else ISSUE.
- ISSUE (1 cycle): sq_issue=1; lat_cnt<=LOOP_LATENCY-1; → WAIT.
- WAIT: if lat_cnt!=0, decrement. If lat_cnt==0:
  - cur_value<=fb_value; iter_rem<=iter_rem-1; iter_done<=iter_done+1.
  - Next state is DONE if iter_rem==1, else ISSUE.
  - fb_value is therefore sampled at the end of cycle issue+LOOP_LATENCY.
- Each iteration costs exactly LOOP_LATENCY+1 cycles.
- result_valid first rises 1+T*(LOOP_LATENCY+1) cycles after the accept cycle.
- DONE: result_valid=1; result_value stable while result_ready is low. On result_ready → IDLE; result_valid drops the next cycle. iter_done holds until the next accept.
- sq_in changes only at an accept or a WAIT capture edge; it is stable during WAIT.
- abort (any state, highest priority): → IDLE next cycle; result_valid, sq_issue, lat_cnt = 0; cur_value retained. start_ready=0 while abort is high, so a simultaneous start is not accepted.
- start_valid outside IDLE is ignored; no queuing.
- T = 2^ITER_W-1 is legal; no wrap handling is needed because iter_rem counts down to 1.
- Reset mid-operation: immediate return to the reset values; an in-flight datapath result is discarded because no capture occurs in IDLE.

Optional Feature:
SQ_LOOP_PERF_EN:
- Defined: perf_cycles clears on accept and increments every cycle in ISSUE or WAIT. It saturates at all-ones and holds through DONE/IDLE until the next accept. abort freezes it.
- Undefined: perf_cycles is tied to 0 and no counter logic is built.

Test Plan:
- LOOP_LATENCY=4, T=0, start_value limbs=i → result_valid 1 cycle after accept, result_value==start_value, sq_issue never pulses, perf_cycles=0.
- T=3, bench datapath returns (x^2 mod N) after 4 cycles → sq_issue at cycles 1,6,11 after accept; result_valid at cycle 16; result matches model; iter_done=3; perf_cycles=15.
- T=2, result_ready held low 10 cycles in DONE → result_valid and result_value stable, start_ready=0 and start_valid ignored; accept on ready → IDLE next cycle.
- T=5, abort asserted in the 2nd WAIT cycle of iteration 2 with start_valid also high → IDLE next cycle, no result_valid, start not taken; a new start accepted the following cycle runs cleanly.
- T=4, rst_n pulsed low mid-WAIT → all outputs take reset values asynchronously; fb_value changes during reset are not captured.
- LOOP_LATENCY=1, T=2 → sq_issue every 2 cycles; result_valid at cycle 5 after accept.

Source files
------------

// File: rtl/sq_loop_ctrl.sv
// sq_loop_ctrl -- sequencer for the iterated modular-squaring loop (VDF).
//
// Loads an initial value and an iteration count T, presents the held value to
// the squarer, waits LOOP_LATENCY cycles for the reduced square to come back,
// captures it, and repeats T times. The final value is offered on a
// valid/ready result port. No arithmetic is done here; only loop state.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_*         load request (valid/ready), iteration count, initial value
//   abort           synchronous cancel, highest priority
//   sq_in/sq_issue  operand to squarer and one-cycle "new operand" pulse
//   fb_value        reduced square returned by the datapath
//   result_*        final value handshake
//   busy, iter_done status: not idle, iterations completed in this run
//   perf_cycles     ISSUE/WAIT cycle counter
//
// Build option: define SQ_LOOP_PERF_EN to build the perf_cycles counter;
// otherwise perf_cycles is tied to zero.

module sq_loop_ctrl #(
   parameter int NUM_ELEMENTS = 33,
   parameter int BIT_LEN      = 17,
   parameter int ITER_W       = 64,
   parameter int LOOP_LATENCY = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start_valid,
   output logic                                   start_ready,
   input  logic [ITER_W-1:0]                      start_iters,
   input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   start_value,
   input  logic                                   abort,
   output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   sq_in,
   output logic                                   sq_issue,
   input  logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   fb_value,
   output logic                                   result_valid,
   input  logic                                   result_ready,
   output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]   result_value,
   output logic                                   busy,
   output logic [ITER_W-1:0]                      iter_done,
   output logic [ITER_W-1:0]                      perf_cycles
);

   // A latency of 1 needs no countdown, but keep a 1-bit counter so widths stay legal.
   localparam int LAT_W = (LOOP_LATENCY > 1) ? $clog2(LOOP_LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(LOOP_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   typedef logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] value_t;

   state_e            state_q, state_d;
   value_t            cur_value_q, cur_value_d;
   logic [ITER_W-1:0] iter_rem_q, iter_rem_d;
   logic [ITER_W-1:0] iter_done_q, iter_done_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic              accept_s;
   logic              lat_zero_s;

   assign accept_s   = start_valid && (state_q == S_IDLE) && !abort;
   assign lat_zero_s = (lat_cnt_q == {LAT_W{1'b0}});

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort overrides every transition.
   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  state_d = (start_iters == {ITER_W{1'b0}}) ? S_DONE : S_ISSUE;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
               if (lat_zero_s) begin
                  // iter_rem never reaches zero in a run, so no wrap handling is needed.
                  state_d = (iter_rem_q == ITER_W'(1)) ? S_DONE : S_ISSUE;
               end else begin
                  state_d = S_WAIT;
               end
            end
            S_DONE: begin
               if (result_ready) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output decode; all outputs come straight from flops except start_ready,
   // which must drop in the same cycle abort is raised.
   always_comb begin
      start_ready  = (state_q == S_IDLE) && !abort;
      sq_issue     = (state_q == S_ISSUE);
      result_valid = (state_q == S_DONE);
      busy         = (state_q != S_IDLE);
      sq_in        = cur_value_q;
      result_value = cur_value_q;
      iter_done    = iter_done_q;
   end

   // Loop-state next values; cur_value only moves on accept or a WAIT capture.
   always_comb begin
      cur_value_d = cur_value_q;
      iter_rem_d  = iter_rem_q;
      iter_done_d = iter_done_q;
      lat_cnt_d   = lat_cnt_q;
      if (abort) begin
         lat_cnt_d = {LAT_W{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  cur_value_d = start_value;
                  iter_rem_d  = start_iters;
                  iter_done_d = {ITER_W{1'b0}};
               end else begin
                  cur_value_d = cur_value_q;
               end
            end
            S_ISSUE: lat_cnt_d = LAT_RELOAD;
            S_WAIT: begin
               if (lat_zero_s) begin
                  cur_value_d = fb_value;
                  iter_rem_d  = iter_rem_q - ITER_W'(1);
                  iter_done_d = iter_done_q + ITER_W'(1);
               end else begin
                  lat_cnt_d = lat_cnt_q - LAT_W'(1);
               end
            end
            default: lat_cnt_d = lat_cnt_q;
         endcase
      end
   end

   // Loop-state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_value_q <= '{default: {BIT_LEN{1'b0}}};
         iter_rem_q  <= {ITER_W{1'b0}};
         iter_done_q <= {ITER_W{1'b0}};
         lat_cnt_q   <= {LAT_W{1'b0}};
      end else begin
         cur_value_q <= cur_value_d;
         iter_rem_q  <= iter_rem_d;
         iter_done_q <= iter_done_d;
         lat_cnt_q   <= lat_cnt_d;
      end
   end

`ifdef SQ_LOOP_PERF_EN
   logic [ITER_W-1:0] perf_cycles_q, perf_cycles_d;

   // Loop cycle counter: cleared on accept, saturating, frozen by abort.
   always_comb begin
      perf_cycles_d = perf_cycles_q;
      if (abort) begin
         perf_cycles_d = perf_cycles_q;
      end else if (accept_s) begin
         perf_cycles_d = {ITER_W{1'b0}};
      end else if (((state_q == S_ISSUE) || (state_q == S_WAIT)) &&
                   (perf_cycles_q != {ITER_W{1'b1}})) begin
         perf_cycles_d = perf_cycles_q + ITER_W'(1);
      end else begin
         perf_cycles_d = perf_cycles_q;
      end
   end

   // Perf counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles_q <= {ITER_W{1'b0}};
      end else begin
         perf_cycles_q <= perf_cycles_d;
      end
   end

   assign perf_cycles = perf_cycles_q;
`else
   assign perf_cycles = {ITER_W{1'b0}};
`endif

endmodule

// File: tb/tb_sq_loop_ctrl.sv
// Testbench for sq_loop_ctrl: a behavioural squarer pipeline feeds fb_value,
// stimulus pushes expected issue cycles and results into queues, and a
// negedge monitor pops and compares them when the DUT presents them.
// A second instance with LOOP_LATENCY=1 is checked cycle by cycle.
`timescale 1ns/1ps
module tb_sq_loop_ctrl;
   localparam int NE  = 33;
   localparam int BL  = 17;
   localparam int IW  = 64;
   localparam int LAT = 4;
`ifdef SQ_LOOP_PERF_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif

   typedef logic [NE-1:0][BL-1:0] val_t;
   typedef struct {
      val_t   value;
      longint iters;
      longint perf;
      int     lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic start_valid = 1'b0, start_valid1 = 1'b0;
   logic abort = 1'b0;
   logic result_ready = 1'b1;
   logic [IW-1:0] start_iters = '0;
   val_t start_value = '0;

   logic start_ready, sq_issue, result_valid, busy;
   val_t sq_in, fb_value, result_value;
   logic [IW-1:0] iter_done, perf_cycles;

   logic start_ready1, sq_issue1, result_valid1, busy1;
   val_t sq_in1, fb_value1, result_value1;
   logic [IW-1:0] iter_done1, perf_cycles1;

   int cyc = 0;
   int acc_cyc = 0;
   int pass_cnt = 0;
   int chk_cnt = 0;
   int iss_q[$];
   exp_t res_q[$];
   exp_t e_res;
   int e_iss;
   logic rv_prev = 1'b0;
   val_t pipe0 [LAT];
   val_t pipe1;

   sq_loop_ctrl #(.NUM_ELEMENTS(NE), .BIT_LEN(BL), .ITER_W(IW), .LOOP_LATENCY(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .start_iters(start_iters), .start_value(start_value), .abort(abort),
      .sq_in(sq_in), .sq_issue(sq_issue), .fb_value(fb_value),
      .result_valid(result_valid), .result_ready(result_ready), .result_value(result_value),
      .busy(busy), .iter_done(iter_done), .perf_cycles(perf_cycles));

   sq_loop_ctrl #(.NUM_ELEMENTS(NE), .BIT_LEN(BL), .ITER_W(IW), .LOOP_LATENCY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid1), .start_ready(start_ready1),
      .start_iters(start_iters), .start_value(start_value), .abort(abort),
      .sq_in(sq_in1), .sq_issue(sq_issue1), .fb_value(fb_value1),
      .result_valid(result_valid1), .result_ready(result_ready), .result_value(result_value1),
      .busy(busy1), .iter_done(iter_done1), .perf_cycles(perf_cycles1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in squarer: per-limb (x*x+3) mod 2^BL.
   function automatic val_t sq_fn(input val_t x);
      val_t r;
      logic [2*BL-1:0] p;
      for (int i = 0; i < NE; i++) begin
         p = {{BL{1'b0}}, x[i]} * {{BL{1'b0}}, x[i]} + 34'd3;
         r[i] = p[BL-1:0];
      end
      return r;
   endfunction

   function automatic val_t iterate(input val_t x, input int t);
      val_t r = x;
      for (int k = 0; k < t; k++) r = sq_fn(r);
      return r;
   endfunction

   function automatic val_t mk_val(input int a, input int b);
      val_t r;
      for (int i = 0; i < NE; i++) r[i] = BL'(a * i + b);
      return r;
   endfunction

   // Datapath models: the good square appears only LAT cycles after an issue;
   // every other cycle carries changing garbage.
   always @(posedge clk) begin
      pipe0[0] <= sq_issue ? sq_fn(sq_in) : (~sq_fn(sq_in) ^ val_t'(cyc));
      for (int k = 1; k < LAT; k++) pipe0[k] <= pipe0[k-1];
      pipe1 <= sq_issue1 ? sq_fn(sq_in1) : (~sq_fn(sq_in1) ^ val_t'(cyc + 7));
   end
   assign fb_value  = pipe0[LAT-1];
   assign fb_value1 = pipe1;

   task automatic chk_int(input string nm, input longint act, input longint exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic chk_val(input string nm, input val_t act, input val_t exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: compare sq_issue pulses and the first cycle of each result.
   always @(negedge clk) begin
      if (sq_issue) begin
         if (iss_q.size() == 0) begin
            chk_int("unexpected_issue_cycle", cyc - acc_cyc, -1);
         end else begin
            e_iss = iss_q.pop_front();
            chk_int("issue_cycle", cyc - acc_cyc, e_iss - acc_cyc);
         end
      end
      if (result_valid && !rv_prev) begin
         if (res_q.size() == 0) begin
            chk_int("unexpected_result_cycle", cyc - acc_cyc, -1);
         end else begin
            e_res = res_q.pop_front();
            chk_int("result_latency", cyc - acc_cyc, e_res.lat);
            chk_val("result_value", result_value, e_res.value);
            chk_int("iter_done", longint'(iter_done), e_res.iters);
            chk_int("perf_cycles", longint'(perf_cycles), e_res.perf);
         end
      end
      rv_prev <= result_valid;
   end

   // Caller is at a negedge; accept happens at the following posedge.
   task automatic start_run(input val_t v, input int t, input int n_iss, input bit push_res);
      exp_t e;
      start_value = v;
      start_iters = IW'(t);
      start_valid = 1'b1;
      #1;
      chk_int("start_ready_at_start", longint'(start_ready), 1);
      acc_cyc = cyc;
      for (int k = 0; k < n_iss; k++) iss_q.push_back(acc_cyc + 1 + k * (LAT + 1));
      if (push_res) begin
         e.value = iterate(v, t);
         e.iters = t;
         e.perf  = PERF_ON ? t * (LAT + 1) : 0;
         e.lat   = 1 + t * (LAT + 1);
         res_q.push_back(e);
      end
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   task automatic wait_to(input int k);
      while (cyc < acc_cyc + k) @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk_int({tag, "_busy"}, longint'(busy), 0);
      chk_int({tag, "_result_valid"}, longint'(result_valid), 0);
      chk_int({tag, "_sq_issue"}, longint'(sq_issue), 0);
      chk_int({tag, "_iter_done"}, longint'(iter_done), 0);
      chk_int({tag, "_perf_cycles"}, longint'(perf_cycles), 0);
      chk_int({tag, "_start_ready"}, longint'(start_ready), 1);
      chk_val({tag, "_sq_in"}, sq_in, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      val_t v, h;
      // Reset state.
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // T=0: result one cycle after accept, no issue.
      @(negedge clk);
      start_run(mk_val(1, 0), 0, 0, 1'b1);
      wait_to(3);
      chk_int("t0_idle_after_ready", longint'(busy), 0);

      // T=3 with full latency check.
      @(negedge clk);
      start_run(mk_val(3, 5), 3, 3, 1'b1);
      wait_to(17);
      chk_int("t3_iter_done_hold", longint'(iter_done), 3);
      chk_int("t3_busy_after", longint'(busy), 0);

      // T=2 with result_ready held low for 10 cycles; start attempts ignored.
      result_ready = 1'b0;
      @(negedge clk);
      v = mk_val(7, 2);
      h = iterate(v, 2);
      start_run(v, 2, 2, 1'b1);
      wait_to(11);
      for (int k = 0; k < 10; k++) begin
         chk_int("hold_result_valid", longint'(result_valid), 1);
         chk_val("hold_result_value", result_value, h);
         chk_int("hold_start_ready", longint'(start_ready), 0);
         start_value = mk_val(11, 9);
         start_valid = 1'b1;
         @(negedge clk);
      end
      start_valid  = 1'b0;
      result_ready = 1'b1;
      @(negedge clk);
      chk_int("hold_rv_drop", longint'(result_valid), 0);
      chk_int("hold_idle", longint'(busy), 0);
      chk_val("hold_start_ignored", sq_in, h);

      // T=5 aborted in the 2nd WAIT cycle of iteration 2, start raised alongside.
      @(negedge clk);
      v = mk_val(5, 1);
      start_run(v, 5, 2, 1'b0);
      wait_to(8);
      abort = 1'b1;
      start_value = mk_val(2, 2);
      start_valid = 1'b1;
      #1 chk_int("abort_start_ready", longint'(start_ready), 0);
      @(negedge clk);
      abort = 1'b0;
      chk_int("abort_idle", longint'(busy), 0);
      chk_int("abort_no_result", longint'(result_valid), 0);
      chk_int("abort_iter_done", longint'(iter_done), 1);
      chk_val("abort_value_retained", sq_in, sq_fn(v));
      start_run(mk_val(4, 6), 1, 1, 1'b1);
      wait_to(7);
      chk_int("after_abort_idle", longint'(busy), 0);

      // T=4 with reset pulsed mid-WAIT.
      @(negedge clk);
      start_run(mk_val(9, 3), 4, 1, 1'b0);
      wait_to(3);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midrst");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk_val("midrst_no_capture", sq_in, '0);
      chk_int("midrst_idle", longint'(busy), 0);

      // LOOP_LATENCY=1 instance, T=2.
      @(negedge clk);
      v = mk_val(6, 4);
      start_value = v;
      start_iters = IW'(2);
      start_valid1 = 1'b1;
      #1 chk_int("l1_start_ready", longint'(start_ready1), 1);
      acc_cyc = cyc;
      @(negedge clk);
      start_valid1 = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         chk_int("l1_sq_issue", longint'(sq_issue1), (k == 1 || k == 3) ? 1 : 0);
         chk_int("l1_result_valid", longint'(result_valid1), (k == 5) ? 1 : 0);
         if (k == 5) begin
            chk_val("l1_result_value", result_value1, iterate(v, 2));
            chk_int("l1_iter_done", longint'(iter_done1), 2);
            chk_int("l1_perf_cycles", longint'(perf_cycles1), PERF_ON ? 4 : 0);
         end
         @(negedge clk);
      end

      chk_int("issue_queue_drained", iss_q.size(), 0);
      chk_int("result_queue_drained", res_q.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
